scan_seq_4b: RTL and testbench

SCAN_SEQ_4B -- requirements
Module: scan_seq_4b

---
 rtl/scan_pkg.sv | 13 +
 rtl/scan_seq_4b_prio_enc16.sv | 17 +
 rtl/scan_seq_4b.sv | 97 +++++++++
 tb/tb_scan_seq_4b.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and sizes for the channel scan sequencer.
package scan_pkg;
  localparam int N_CH  = 16;
  localparam int SEL_W = 4;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/scan_seq_4b_prio_enc16.sv
// Lowest-set-bit priority encoder over the 16 channel request bits.
import scan_pkg::*;

module prio_enc16 (
  input  logic [N_CH-1:0]  vec_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             any_o
);
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    // Walk downward so the lowest set bit is the last one written.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = SEL_W'(i);
    end
  end
endmodule

// File: rtl/scan_seq_4b.sv
// Scan sequencer: visits each masked channel in ascending order, holding
// sel live for dwell+1 cycles with a one-cycle break between channels.
import scan_pkg::*;

module scan_seq_4b #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [N_CH-1:0]    mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   ch_count
);
  state_e               state_q;
  logic [N_CH-1:0]      pending_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic [DWELL_W-1:0]   cnt_q;
  logic [SEL_W-1:0]     sel_q;
  logic                 sel_valid_q;
  logic                 done_q;
  logic [CNT_W-1:0]     ch_count_q;

  logic [SEL_W-1:0]     nxt_idx;
  logic                 nxt_any;

  prio_enc16 u_enc (
    .vec_i (pending_q),
    .idx_o (nxt_idx),
    .any_o (nxt_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ch_count_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            pending_q  <= mask;
            dwell_q    <= dwell;
            ch_count_q <= '0;
            state_q    <= SEEK;
          end
        end
        SEEK: begin
          if (stop || !nxt_any) begin
            sel_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            sel_q       <= nxt_idx;
            pending_q   <= pending_q & ~(N_CH'(1) << nxt_idx);
            sel_valid_q <= 1'b1;
            cnt_q       <= dwell_q;
            ch_count_q  <= ch_count_q + CNT_W'(1);
            state_q     <= DWELL;
          end
        end
        DWELL: begin
          // Abort wins over normal expiry so the channel is dropped at once.
          if (stop) begin
            sel_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end else begin
            sel_valid_q <= 1'b0;
            state_q     <= SEEK;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign busy      = (state_q == SEEK) || (state_q == DWELL);
  assign done      = done_q;
  assign ch_count  = ch_count_q;
endmodule

// File: tb/tb_scan_seq_4b.sv
// Directed bench for scan_seq_4b: table of passes checked cycle by cycle
// against an expected trace, plus reset and ignored-input sequences.
module tb_scan_seq_4b;
  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [15:0] mask;
  logic [3:0]  dwell;
  logic [3:0]  sel;
  logic        sel_valid, busy, done;
  logic [4:0]  ch_count;

  int errors = 0;
  int checks = 0;

  scan_seq_4b #(.DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mask(mask),
    .dwell(dwell), .sel(sel), .sel_valid(sel_valid), .busy(busy),
    .done(done), .ch_count(ch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic       v;
    logic       b;
    logic       d;
    logic [4:0] cnt;
  } ent_t;

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  dwell;
    int          stop_at;
    int          perturb;
    logic [4:0]  exp_cnt;
  } vec_t;

  ent_t       q[$];
  logic [3:0] exp_sel;

  function automatic ent_t mk(input int s, input logic v, input logic b,
                              input logic d, input int c);
    ent_t e;
    e.sel = 4'(s); e.v = v; e.b = b; e.d = d; e.cnt = 5'(c);
    return e;
  endfunction

  task automatic chk(input string name, input int idx, input ent_t exp);
    checks++;
    if (sel !== exp.sel || sel_valid !== exp.v || busy !== exp.b ||
        done !== exp.d || ch_count !== exp.cnt) begin
      errors++;
      $display("FAIL %s cyc%0d: got sel=%0d v=%0b busy=%0b done=%0b cnt=%0d want sel=%0d v=%0b busy=%0b done=%0b cnt=%0d",
               name, idx, sel, sel_valid, busy, done, ch_count,
               exp.sel, exp.v, exp.b, exp.d, exp.cnt);
    end
  endtask

  // Expected output trace, one entry per cycle after the start edge.
  task automatic build(input logic [15:0] m, input logic [3:0] dw, input int stop_at);
    int   n;
    int   cur;
    ent_t e;
    q.delete();
    cur = exp_sel;
    n   = 0;
    q.push_back(mk(cur, 1'b0, 1'b1, 1'b0, 0));
    for (int ch = 0; ch < 16; ch++) begin
      if (m[ch]) begin
        n++;
        cur = ch;
        for (int k = 0; k <= int'(dw); k++) q.push_back(mk(ch, 1'b1, 1'b1, 1'b0, n));
        q.push_back(mk(ch, 1'b0, 1'b1, 1'b0, n));
      end
    end
    q.push_back(mk(cur, 1'b0, 1'b0, 1'b1, n));
    if (stop_at >= 0 && stop_at < q.size() - 1) begin
      e = q[stop_at];
      while (q.size() > stop_at + 1) void'(q.pop_back());
      q.push_back(mk(e.sel, 1'b0, 1'b0, 1'b1, e.cnt));
    end
    e   = q[q.size()-1];
    e.d = 1'b0;
    q.push_back(e);
    q.push_back(e);
  endtask

  task automatic run_pass(input string name, input vec_t t);
    ent_t last;
    build(t.mask, t.dwell, t.stop_at);
    @(negedge clk);
    start = 1'b1; mask = t.mask; dwell = t.dwell;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      chk(name, i, q[i]);
      if (i == t.stop_at) stop = 1'b1;
      if (t.perturb != 0) begin
        if (i == 3) start = 1'b1;
        if (i == 2) begin mask = 16'hFFFF; dwell = 4'd9; end
      end
    end
    stop = 1'b0;
    last = q[q.size()-1];
    exp_sel = last.sel;
    checks++;
    if (last.cnt !== t.exp_cnt) begin
      errors++;
      $display("FAIL %s final_count: model=%0d want=%0d", name, last.cnt, t.exp_cnt);
    end
  endtask

  vec_t tbl[8];
  ent_t z;

  initial begin
    tbl[0] = '{16'h0005, 4'd2,  -1, 0, 5'd2};   // basic
    tbl[1] = '{16'h0000, 4'd2,  -1, 0, 5'd0};   // empty mask
    tbl[2] = '{16'hFFFF, 4'd0,  -1, 0, 5'd16};  // full sweep
    tbl[3] = '{16'h8001, 4'd7,   4, 0, 5'd1};   // abort in ch0 dwell cycle 3
    tbl[4] = '{16'h0005, 4'd2,  -1, 1, 5'd2};   // ignored start/mask/dwell
    tbl[5] = '{16'h8421, 4'd3,  -1, 0, 5'd4};
    tbl[6] = '{16'h0001, 4'd15, -1, 0, 5'd1};   // longest dwell
    tbl[7] = '{16'h0300, 4'd1,   0, 0, 5'd0};   // stop in first SEEK

    rst = 1'b1; start = 1'b0; stop = 1'b0; mask = '0; dwell = '0;
    exp_sel = 4'd0;
    z = mk(0, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    start = 1'b1; stop = 1'b1; mask = 16'hFFFF;
    @(negedge clk);
    chk("reset_state", 0, z);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("stop_in_idle", 0, z);
    stop = 1'b0;

    for (int i = 0; i < 8; i++) run_pass($sformatf("vec%0d", i), tbl[i]);

    // Reset during ch4 dwell: everything clears, no done afterwards.
    @(negedge clk);
    start = 1'b1; mask = 16'h00F0; dwell = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (sel !== 4'd4 || sel_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got sel=%0d v=%0b want sel=4 v=1", sel, sel_valid);
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("mid_reset", 0, z);
    rst = 1'b0; start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("post_reset", i, z);
    end
    exp_sel = 4'd0;
    run_pass("after_reset", '{16'h00F0, 4'd3, -1, 0, 5'd4});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
